// File: rtl/wb_fifo_slave_pkg.sv
// rtl/wb_fifo_slave_pkg.sv - shared register map, control bit positions and FSM state type
package wb_fifo_slave_pkg;

    // Register select values taken from sa_adr_i[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_THRESH  = 2'd3;

    // CONTROL register bit positions
    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// rtl/wb_fifo_mem.sv - FIFO storage array, one write port and one asynchronous read port
//
// Ports:
//   clk   - write clock
//   we    - write enable, stores wdata at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - word currently stored at raddr
// The array is deliberately not reset; only the pointers that index it are.
module wb_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_fifo_slave.sv
// rtl/wb_fifo_slave.sv - Wishbone-style bus slave exposing a word FIFO with status, control and threshold IRQ
//
// Ports:
//   clk, reset           - clock and asynchronous active-low reset
//   sa_adr_i             - address, sa_adr_i[3:2] selects DATA/STATUS/CONTROL/THRESH
//   sa_dat_i, sa_sel_i   - write data (full word, byte selects ignored)
//   sa_tag_i             - bus tags, ignored
//   sa_we_i              - write enable
//   sa_stb_i, sa_cyc_i   - strobe and cycle; a transfer is accepted when both are high in IDLE
//   sa_dat_o             - registered read data, zero outside of a termination cycle
//   sa_ack_o, sa_err_o   - one-cycle termination, exactly one per accepted transfer
//   sa_rty_o             - never asserted
//   irq_o                - registered level interrupt: irq_en and count >= non-zero THRESH
module wb_fifo_slave
    import wb_fifo_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TAG_WIDTH  = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] sa_adr_i,
    input  logic [DATA_WIDTH-1:0] sa_dat_i,
    input  logic [SEL_WIDTH-1:0]  sa_sel_i,
    input  logic [TAG_WIDTH-1:0]  sa_tag_i,
    input  logic                  sa_we_i,
    input  logic                  sa_stb_i,
    input  logic                  sa_cyc_i,
    output logic [DATA_WIDTH-1:0] sa_dat_o,
    output logic                  sa_ack_o,
    output logic                  sa_err_o,
    output logic                  sa_rty_o,
    output logic                  irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t                state, state_nx;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, thresh;
    logic                  irq_en;
    logic [DATA_WIDTH-1:0] head_word, rd_word;
    logic [1:0]            reg_sel;
    logic                  full, empty, commit;
    logic                  push, pop, bus_err, flush, ctrl_wr, thr_wr;

    // Byte selects, tags and unused address/data bits have no effect on the block
    wire unused_inputs = &{1'b0, sa_sel_i, sa_tag_i, sa_adr_i, sa_dat_i};

    assign sa_rty_o = 1'b0;
    assign reg_sel  = sa_adr_i[3:2];
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign commit   = (state == ST_IDLE) && sa_stb_i && sa_cyc_i;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (sa_stb_i && sa_cyc_i) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        push    = commit && sa_we_i  && (reg_sel == REG_DATA) && !full;
        pop     = commit && !sa_we_i && (reg_sel == REG_DATA) && !empty;
        bus_err = commit && (reg_sel == REG_DATA) && (sa_we_i ? full : empty);
        ctrl_wr = commit && sa_we_i && (reg_sel == REG_CONTROL);
        thr_wr  = commit && sa_we_i && (reg_sel == REG_THRESH);
        flush   = ctrl_wr && sa_dat_i[CTRL_FLUSH_BIT];
    end

    // Read-data mux; an empty DATA read leaves the word at zero
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA:    if (!empty) rd_word = head_word;
            REG_STATUS:  rd_word[CNT_W+1:0] = {count, full, empty};
            REG_CONTROL: rd_word[CTRL_IRQ_EN_BIT] = irq_en;
            REG_THRESH:  rd_word[CNT_W-1:0] = thresh;
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            thresh   <= '0;
            irq_en   <= 1'b0;
            sa_ack_o <= 1'b0;
            sa_err_o <= 1'b0;
            sa_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            sa_ack_o <= commit && !bus_err;
            sa_err_o <= bus_err;
            sa_dat_o <= (commit && !sa_we_i) ? rd_word : '0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end

            if (ctrl_wr) irq_en <= sa_dat_i[CTRL_IRQ_EN_BIT];
            if (thr_wr)  thresh <= sa_dat_i[CNT_W-1:0];

            irq_o <= irq_en && (thresh != '0) && (count >= thresh);
        end
    end

    wb_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (sa_dat_i),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

endmodule

// File: tb/tb_wb_fifo_slave.sv
// tb/tb_wb_fifo_slave.sv - scoreboard bench for wb_fifo_slave against a queue-based reference model
module tb_wb_fifo_slave;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sa_adr_i = '0;
    logic [31:0] sa_dat_i = '0;
    logic [3:0]  sa_sel_i = '0;
    logic [2:0]  sa_tag_i = '0;
    logic        sa_we_i = 1'b0;
    logic        sa_stb_i = 1'b0;
    logic        sa_cyc_i = 1'b0;
    logic [31:0] sa_dat_o;
    logic        sa_ack_o, sa_err_o, sa_rty_o, irq_o;

    wb_fifo_slave dut (
        .clk      (clk),
        .reset    (reset),
        .sa_adr_i (sa_adr_i),
        .sa_dat_i (sa_dat_i),
        .sa_sel_i (sa_sel_i),
        .sa_tag_i (sa_tag_i),
        .sa_we_i  (sa_we_i),
        .sa_stb_i (sa_stb_i),
        .sa_cyc_i (sa_cyc_i),
        .sa_dat_o (sa_dat_o),
        .sa_ack_o (sa_ack_o),
        .sa_err_o (sa_err_o),
        .sa_rty_o (sa_rty_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        chk_dat;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference model state
    logic [31:0] m_fifo[$];
    int          m_thresh = 0;
    bit          m_irq_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit model_irq();
        return m_irq_en && (m_thresh != 0) && (m_fifo.size() >= m_thresh);
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_thresh = 0;
        m_irq_en = 0;
    endfunction

    // Applies one access to the reference model and returns the expected termination
    function automatic exp_t model_access(input bit we, input int rsel, input logic [31:0] d);
        exp_t e;
        e.ack = 1'b1;
        e.chk_dat = !we;
        e.dat = '0;
        case (rsel)
            0: begin
                e.name = we ? "data_wr" : "data_rd";
                if (we) begin
                    if (m_fifo.size() == DEPTH) e.ack = 1'b0;
                    else m_fifo.push_back(d);
                end else begin
                    if (m_fifo.size() == 0) e.ack = 1'b0;
                    else e.dat = m_fifo.pop_front();
                end
            end
            1: begin
                e.name = "status";
                e.dat = (m_fifo.size() << 2) | ((m_fifo.size() == DEPTH) << 1) | (m_fifo.size() == 0);
            end
            2: begin
                e.name = "control";
                if (we) begin
                    m_irq_en = d[1];
                    if (d[0]) m_fifo.delete();
                end else e.dat = {30'd0, m_irq_en, 1'b0};
            end
            default: begin
                e.name = "thresh";
                if (we) m_thresh = int'(d[3:0]);
                else e.dat = m_thresh;
            end
        endcase
        return e;
    endfunction

    // One bus transfer: checks irq against the model at the idle boundary, then
    // strobes for one cycle and drops stb/cyc in the termination cycle.
    task automatic xfer(input bit we, input int rsel, input logic [31:0] d);
        @(negedge clk);
        check("irq_idle", {31'd0, irq_o}, {31'd0, model_irq()});
        exp_q.push_back(model_access(we, rsel, d));
        sa_we_i  = we;
        sa_adr_i = 32'(rsel) << 2;
        sa_dat_i = d;
        sa_sel_i = 4'($urandom);
        sa_tag_i = 3'($urandom);
        sa_stb_i = 1'b1;
        sa_cyc_i = 1'b1;
        @(negedge clk);
        sa_stb_i = 1'b0;
        sa_cyc_i = 1'b0;
    endtask

    // Monitor: every termination pops one expectation
    always @(negedge clk) begin
        if (sa_ack_o || sa_err_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_term: ack=%0b err=%0b with nothing outstanding", sa_ack_o, sa_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_term"}, {30'd0, sa_ack_o, sa_err_o}, {30'd0, e.ack, !e.ack});
                if (e.chk_dat) check({e.name, "_dat"}, sa_dat_o, e.dat);
            end
            check("rty", {31'd0, sa_rty_o}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bit prev_ack;

        #1;
        check("rst_ack", {31'd0, sa_ack_o}, 32'd0);
        check("rst_err", {31'd0, sa_err_o}, 32'd0);
        check("rst_dat", sa_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Fill to full, overflow, then drain and underflow
        for (int i = 1; i <= 8; i++) xfer(1, 0, 32'(i * 8'h11));
        xfer(1, 0, 32'hdead_beef);
        xfer(0, 1, 0);
        for (int i = 0; i < 9; i++) xfer(0, 0, 0);
        xfer(0, 1, 0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) xfer(1, 0, $urandom);
        for (int i = 0; i < 5; i++) xfer(0, 0, 0);
        for (int i = 0; i < 6; i++) xfer(1, 0, $urandom);
        for (int i = 0; i < 6; i++) xfer(0, 0, 0);

        // Threshold interrupt: rises one cycle after the third commit
        xfer(1, 3, 32'hffff_fff3);
        xfer(0, 3, 0);
        xfer(1, 2, 32'h2);
        xfer(0, 2, 0);
        xfer(1, 0, 32'ha1);
        xfer(1, 0, 32'ha2);
        xfer(1, 0, 32'ha3);
        check("irq_at_commit", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq_o}, 32'd1);
        xfer(0, 0, 0);
        xfer(1, 2, 32'h3);
        xfer(0, 1, 0);

        // Strobe held for six cycles: three acks, never back to back
        for (int i = 0; i < 3; i++) exp_q.push_back(model_access(0, 1, 0));
        @(negedge clk);
        sa_we_i = 1'b0;
        sa_adr_i = 32'h4;
        sa_stb_i = 1'b1;
        sa_cyc_i = 1'b1;
        acks = 0;
        prev_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sa_ack_o) acks++;
            if (sa_ack_o && prev_ack) check("ack_consecutive", 32'd1, 32'd0);
            prev_ack = sa_ack_o;
        end
        sa_stb_i = 1'b0;
        sa_cyc_i = 1'b0;
        check("held_stb_acks", acks, 32'd3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int rsel;
            bit we;
            logic [31:0] d;
            rsel = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            we = $urandom_range(0, 1) == 1;
            d = $urandom;
            if (rsel == 2 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
            xfer(we, rsel, d);
        end

        // Reset during the termination cycle of a push with irq asserted
        xfer(1, 2, 32'h3);
        xfer(1, 3, 32'h1);
        xfer(1, 0, 32'h55);
        xfer(1, 0, 32'h66);
        @(negedge clk);
        check("irq_pre_reset", {31'd0, irq_o}, 32'd1);
        sa_we_i = 1'b1;
        sa_adr_i = 32'h0;
        sa_dat_i = 32'h77;
        sa_stb_i = 1'b1;
        sa_cyc_i = 1'b1;
        @(posedge clk);
        #2;
        check("ack_pre_reset", {31'd0, sa_ack_o}, 32'd1);
        reset = 1'b0;
        #1;
        check("ack_in_reset", {31'd0, sa_ack_o}, 32'd0);
        check("irq_in_reset", {31'd0, irq_o}, 32'd0);
        sa_stb_i = 1'b0;
        sa_cyc_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        xfer(0, 1, 0);
        xfer(0, 3, 0);
        xfer(0, 0, 0);

        repeat (3) @(negedge clk);
        check("outstanding", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
